// File: rtl/gaussian_blur.sv
// gaussian_blur: streams a raster image through a 3x3 [1 2 1;2 4 2;1 2 1]/16 smoothing filter
module gaussian_blur #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              ird,
    output logic [ADDR_W-1:0] iaddr,
    input  logic [7:0]        idata,
    output logic              gwr,
    output logic [ADDR_W-1:0] gaddr,
    output logic [7:0]        gdata,
    output logic              done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int SW = ADDR_W + 1;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   cnt, cnt_n;
    logic            start;
    logic            rd_q;
    logic [SW-1:0]   sidx;
    logic [CW-1:0]   col;
    logic [CW-1:0]   ocol;
    logic [RW-1:0]   orow;
    logic [ADDR_W-1:0] ocnt;
    logic [7:0]      lb1 [IMG_W];
    logic [7:0]      lb2 [IMG_W];
    logic [7:0]      t1, m1, b1, t2, m2, b2;
    logic [7:0]      px, nt, nm, blur;
    logic [11:0]     sum;
    logic            proc, wr, border;

    // state and phase counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next state, phase counter and read-side outputs
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) state_n = RUN;
            end
            RUN: if (cnt == SW'(N - 1)) begin
                state_n = FLUSH;
                cnt_n   = '0;
            end
            FLUSH: if (cnt == SW'(IMG_W)) begin
                state_n = DRAIN;
                cnt_n   = '0;
            end
            DRAIN: if (cnt == SW'(1)) begin
                state_n = DONE;
                cnt_n   = '0;
            end
            DONE: begin
                cnt_n = '0;
                if (!enable) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        ird   = state == RUN;
        iaddr = ird ? cnt[ADDR_W-1:0] : '0;
        done  = state == DONE;
    end

    // a pixel enters the window when a read returns or while flushing the last rows with zeros
    always_comb begin
        start  = state == IDLE && enable;
        proc   = !start && (rd_q || (sidx >= SW'(N) && sidx < SW'(N + IMG_W + 1)));
        wr     = proc && sidx > SW'(IMG_W);
        px     = rd_q ? idata : 8'd0;
        nt     = lb2[col];
        nm     = lb1[col];
        sum    = 12'(t1) + 12'(b1) + 12'(nt) + 12'(px)
               + ((12'(m1) + 12'(nm) + 12'(t2) + 12'(b2)) << 1)
               + (12'(m2) << 2);
        blur   = 8'((sum + 12'd8) >> 4);
        border = orow == '0 || orow == RW'(IMG_H - 1) || ocol == '0 || ocol == CW'(IMG_W - 1);
    end

    // line buffers hold the two previous rows; contents need no reset
    always_ff @(posedge clk) begin
        if (proc) begin
            lb2[col] <= nm;
            lb1[col] <= px;
        end
    end

    // window shift, stream/output counters and registered write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q  <= 1'b0;
            sidx  <= '0;
            col   <= '0;
            ocol  <= '0;
            orow  <= '0;
            ocnt  <= '0;
            {t1, m1, b1, t2, m2, b2} <= '0;
            gwr   <= 1'b0;
            gaddr <= '0;
            gdata <= '0;
        end else begin
            rd_q <= ird;
            gwr  <= wr;
            if (start) begin
                sidx <= '0;
                col  <= '0;
                ocol <= '0;
                orow <= '0;
                ocnt <= '0;
            end else if (proc) begin
                sidx <= sidx + 1'b1;
                col  <= col == CW'(IMG_W - 1) ? '0 : col + 1'b1;
                {t1, m1, b1} <= {t2, m2, b2};
                {t2, m2, b2} <= {nt, nm, px};
                if (wr) begin
                    gaddr <= ocnt;
                    gdata <= border ? m2 : blur;
                    ocnt  <= ocnt + 1'b1;
                    ocol  <= ocol == CW'(IMG_W - 1) ? '0 : ocol + 1'b1;
                    orow  <= ocol == CW'(IMG_W - 1) ? orow + 1'b1 : orow;
                end
            end
        end
    end
endmodule

// File: tb/tb_gaussian_blur.sv
// tb_gaussian_blur: randomized and directed checks of gaussian_blur against a 2-D arithmetic model
module tb_gaussian_blur;
    localparam int W  = 128;
    localparam int H  = 128;
    localparam int N  = W * H;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          ird, gwr, done;
    logic [AW-1:0] iaddr, gaddr;
    logic [7:0]    idata = 8'd0;
    logic [7:0]    gdata;

    logic [7:0] src [N];
    logic [7:0] img [N];

    int     total = 0;
    int     bad = 0;
    longint t_en = 0;
    int     cyc, nw, gaps, first_w, last_w, done_c, nrd, rdbad;

    gaussian_blur #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .ird(ird), .iaddr(iaddr), .idata(idata),
        .gwr(gwr), .gaddr(gaddr), .gdata(gdata), .done(done)
    );

    always #5 clk = ~clk;

    // source ROM with one cycle of read latency
    always @(posedge clk) idata <= src[iaddr];

    // observe the DUT shortly after each rising edge; cyc is the cycle index from the first RUN cycle
    always @(posedge clk) begin
        #2;
        cyc = int'(($time - t_en - 7) / 10);
        if (ird) begin
            if (int'(iaddr) != nrd || cyc != nrd) rdbad++;
            nrd++;
        end
        if (gwr) begin
            if (nw == 0) first_w = cyc;
            if (int'(gaddr) != nw) gaps++;
            img[gaddr] = gdata;
            last_w = cyc;
            nw++;
        end
        if (done && done_c < 0) done_c = cyc;
    end

    function automatic int ref_px(int r, int c);
        int s;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return int'(src[r * W + c]);
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * int'(src[(r + dr) * W + c + dc]);
        return (s + 8) / 16;
    endfunction

    task automatic img_errs(output int n, output int first);
        n = 0;
        first = -1;
        for (int i = 0; i < N; i++)
            if (int'(img[i]) != ref_px(i / W, i % W)) begin
                if (first < 0) first = i;
                n++;
            end
    endtask

    task automatic start_pass();
        @(negedge clk);
        nw = 0; gaps = 0; first_w = -1; last_w = -1; done_c = -1; nrd = 0; rdbad = 0;
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        t_en = $time;
        enable = 1'b1;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20000 && to; i++) begin
            @(negedge clk);
            if (done) to = 1'b0;
        end
    endtask

    task automatic full_pass(input string name);
        bit to;
        int n, first;
        int got [8];
        int want [8];
        string tag [8];
        wait_done(to);
        img_errs(n, first);
        got  = '{int'(to), nw, gaps, first_w, last_w, done_c, rdbad, n};
        want = '{0, N, 0, 131, 16514, 16515, 0, 0};
        tag  = '{"timeout", "writes", "addr_gaps", "first_write_cycle", "last_write_cycle",
                 "done_cycle", "read_seq_errs", "pixel_errs"};
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got[i] != want[i]) begin
                bad++;
                $display("FAIL %s %s: got %0d want %0d (first bad pixel %0d)", name, tag[i], got[i], want[i], first);
            end
        end
        total++;
        if (nrd != N) begin
            bad++;
            $display("FAIL %s reads: got %0d want %0d", name, nrd, N);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ird, gwr, done, iaddr, gaddr, gdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ird=%b gwr=%b done=%b iaddr=%0d gaddr=%0d gdata=%0d want all 0",
                     ird, gwr, done, iaddr, gaddr, gdata);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ird !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_enable: ird=%b done=%b want 0 0", ird, done);
        end
    endtask

    task automatic test_impulse_rounding();
        int idx [11] = '{64*W+64, 63*W+64, 65*W+64, 64*W+63, 64*W+65, 63*W+63, 65*W+65,
                         10*W+10, 9*W+10, 11*W+11, 12*W+12};
        int val [11] = '{40, 20, 20, 20, 20, 10, 10, 2, 1, 1, 0};
        for (int i = 0; i < N; i++) src[i] = 8'd0;
        src[64*W+64] = 8'd160;
        src[10*W+10] = 8'd8;
        start_pass();
        full_pass("impulse");
        for (int i = 0; i < 11; i++) begin
            total++;
            if (int'(img[idx[i]]) != val[i]) begin
                bad++;
                $display("FAIL impulse_pixel[%0d]: got %0d want %0d", idx[i], img[idx[i]], val[i]);
            end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_border();
        int idx [5] = '{0, 5*W, 5*W+127, 127*W+127, 64*W+1};
        int val [5] = '{0, 0, 254, 254, 2};
        for (int i = 0; i < N; i++) src[i] = 8'(2 * (i % W));
        start_pass();
        full_pass("border");
        for (int i = 0; i < 5; i++) begin
            total++;
            if (int'(img[idx[i]]) != val[i]) begin
                bad++;
                $display("FAIL border_pixel[%0d]: got %0d want %0d", idx[i], img[idx[i]], val[i]);
            end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < N; i++) src[i] = 8'd255;
        start_pass();
        repeat (5001) @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({ird, gwr, done} !== 3'b000 || iaddr !== '0) begin
            bad++;
            $display("FAIL midrun_reset: ird=%b gwr=%b done=%b iaddr=%0d want 0 0 0 0", ird, gwr, done, iaddr);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ird !== 1'b0) begin
            bad++;
            $display("FAIL midrun_idle: ird=%b want 0", ird);
        end
        start_pass();
        full_pass("restart_255");
        total++;
        if (img[N/2] !== 8'd255) begin
            bad++;
            $display("FAIL saturate_pixel: got %0d want 255", img[N/2]);
        end
    endtask

    task automatic test_handshake();
        int rd0 = nrd;
        int drops = 0;
        repeat (50) begin
            @(negedge clk);
            if (done !== 1'b1) drops++;
        end
        total++;
        if (drops != 0 || nrd != rd0) begin
            bad++;
            $display("FAIL hold_done: done drops=%0d new reads=%0d want 0 0", drops, nrd - rd0);
        end
        enable = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_release: got %b want 0", done);
        end
        for (int i = 0; i < N; i++) src[i] = 8'($urandom_range(0, 255));
        start_pass();
        full_pass("random_second_pass");
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) src[i] = 8'd0;
        test_reset();
        test_impulse_rounding();
        test_border();
        test_reset_midrun();
        test_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gaussian_blur.md
Name: gaussian_blur

Overview:
Pre-filter stage directly upstream of the Canny edge detector. Streams a 128x128 8-bit grayscale image from the source ROM in raster order and applies a 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16. Writes a smoothed 128x128 image into the RAM that the edge detector later reads through its iaddr/idata port. Uses two line buffers, so each source pixel is read exactly once, at one pixel per clock.

Parameters:
IMG_W, 128, image width in pixels
IMG_H, 128, image height in pixels
ADDR_W, 14, pixel address width; IMG_W*IMG_H <= 2^ADDR_W

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-low reset
enable  input  1  start request; sampled only in IDLE
ird  output  1  source read strobe
iaddr  output  ADDR_W  source pixel address, raster order (row*IMG_W+col)
idata  input  8  source pixel; valid in the cycle after ird=1/iaddr is presented (1-cycle read latency)
gwr  output  1  smoothed-image write strobe
gaddr  output  ADDR_W  smoothed-image write address
gdata  output  8  smoothed pixel
done  output  1  image complete

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; ird=0, iaddr=0, gwr=0, gaddr=0, gdata=0, done=0. Counters and window registers are cleared. Line-buffer contents are don't-care.
- Reset mid-operation: the same values take effect on the next edge. In-flight reads and writes are abandoned. A new enable restarts from pixel 0.
- State IDLE: if enable=1, go to RUN.
- State RUN: in RUN cycle k (k = 0..N-1, N=IMG_W*IMG_H), drive ird=1 and iaddr=k. After cycle N-1, go to FLUSH.
- State FLUSH: lasts IMG_W+1 cycles (129). ird=0. The pipeline keeps shifting with a dummy pixel 0. Then go to DRAIN.
- State DRAIN: waits the 2 pipeline cycles for the last write to leave, then goes to DONE.
- State DONE: done=1. Stay while enable=1. When enable=0, go to IDLE with done=0 on that edge.
- enable is ignored outside IDLE.
- Pipeline stage 1: idata for address a is captured in cycle a+1.
- Line buffers lb1 and lb2 (IMG_W x 8 each), both indexed by column c = a mod IMG_W.
  - The new window column is {lb2[c], lb1[c], idata}.
  - Then lb2[c] <= lb1[c] and lb1[c] <= idata.
- The 3x3 window shifts left by one column per accepted pixel, including across row wraps and during FLUSH.
- Invariant: after the shift for stream index a, the window centre tap equals source pixel a-(IMG_W+1).
- Stream indices a <= IMG_W (first 129) produce no write.
- Every later index, including the 129 FLUSH indices, produces exactly one write. gaddr runs 0..N-1 in strictly increasing, contiguous order: N writes total, one per cycle, with no gaps.
- Write timing: the write for gaddr = a-129 is asserted in cycle a+2 (registered).
  - First write: gaddr=0 in RUN cycle 131.
  - Last write: gaddr=16383 in cycle 16514.
  - done rises in cycle 16515.
- Output value for output coordinate (r,c) = (gaddr/IMG_W, gaddr mod IMG_W):
  - Interior (1<=r<=IMG_H-2 and 1<=c<=IMG_W-2): sum = corners + 2*edges + 4*centre, 12-bit unsigned, max 4080. gdata = (sum+8)>>4, i.e. round half up; result is always <= 255, no clamp needed.
  - Border (r or c equal to 0 or the max index): gdata = centre tap (passthrough).
- gwr=0 in every cycle that carries no write. gaddr/gdata hold their last values when gwr=0.

Test Plan:
- Constant image, all pixels 100 -> exactly 16384 writes, gaddr 0..16383 contiguous, every gdata=100; first gwr in RUN cycle 131; done=1 in cycle 16515.
- Impulse: pixel (64,64)=160, all others 0 -> gdata(64,64)=40; (63,64), (65,64), (64,63), (64,65) = 20; the four diagonals = 10; all other addresses 0.
- Rounding: pixel (10,10)=8, all others 0 -> (10,10)=2, edge neighbours=1 (24>>4), diagonals=1 (16>>4), rest 0. All pixels 255 -> all outputs 255, no overflow.
- Border/row-wrap: pixel = 2*col -> every output equals 2*col, including column 0 = 0 and column 127 = 254. Confirms no cross-row contamination at the wrap.
- Reset mid-run: rst=0 for one cycle at RUN cycle 5000 -> next cycle ird=gwr=done=0 and state IDLE. Re-assert enable -> complete, correct constant-image output with 16384 writes.
- Handshake: enable held high after done -> done stays 1 and no new reads occur. Drop enable -> done=0 next edge. Re-raise enable -> second full pass starting at iaddr=0.
